xbar_route_scheduler: RTL and testbench
=======================================

// Module: xbar_route_scheduler
// PURPOSE
//  Sequences the blocking crossbar through a programmed list of routes (input->output, N transfers each).
//  Software loads up to N_ENTRIES route entries, pulses go, and the block issues each control word.
//  It counts completed transfers on the routed output, then advances to the next route and signals done.
//  path_en gates the crossbar data handshake at top level, so no transfer crosses a route change.
// PARAMETERS
//  N_INPUTS           2   crossbar inputs (>=2); IW = $clog2(N_INPUTS)
//  N_OUTPUTS          2   crossbar outputs (>=2); OW = $clog2(N_OUTPUTS)
//  CONTROL_BIT_WIDTH  42  crossbar control word width (>= IW+OW)
//  N_ENTRIES          4   route table depth (>=1)
//  COUNT_WIDTH        8   transfers-per-route field width
// PORTS
//  clk              in   1                   clock
//  reset            in   1                   synchronous, active-high reset
//  cfg_msg          in   IW+OW+COUNT_WIDTH   route entry {in_sel, out_sel, count}
//  cfg_val          in   1                   route entry valid
//  cfg_rdy          out  1                   table accepts entry
//  go               in   1                   start executing table (sampled in IDLE only)
//  busy             out  1                   state != IDLE
//  done             out  1                   one-cycle pulse: last route finished
//  xbar_control     out  CONTROL_BIT_WIDTH   {in_sel, out_sel, zero-pad} to crossbar
//  xbar_control_val out  1                   control word valid
//  xbar_control_rdy in   1                   crossbar accepts control
//  path_en          out  1                   top ANDs into routed recv_val/send_rdy
//  mon_val          in   N_OUTPUTS           crossbar send_val per output
//  mon_rdy          in   N_OUTPUTS           crossbar send_rdy per output, after path_en gating
// BEHAVIOUR
//  Reset: state=IDLE, table count=0, ptr=0, xfer counter=0.
//  Reset values: cfg_rdy=0 while reset is high; busy=0, done=0, xbar_control=0, xbar_control_val=0, path_en=0.
//  cfg_rdy = (state==IDLE) && (entries<N_ENTRIES). An entry is written at tail on cfg_val&&cfg_rdy.
//  IDLE: go && entries>0 -> ISSUE with ptr=0. go with an empty table is ignored (no done).
//    A same-cycle cfg write and go: the entry is written and included in the run.
//  ISSUE: if entry.count==0, skip it (no control issued); advance ptr, or go to DONE if it was the last entry.
//    Otherwise drive xbar_control_val=1 with the entry's control word and hold it until xbar_control_rdy.
//    On fire -> RUN with counter=0. The crossbar latches the route on that edge, so it is valid from the next cycle.
//  RUN: path_en=1. Fire = mon_val[out_sel] && mon_rdy[out_sel]; fires on other outputs are ignored.
//    Counter increments on each fire (unsigned, COUNT_WIDTH bits).
//    Fire when counter==count-1 -> path_en drops next cycle. Advance ptr and go to ISSUE,
//    or go to DONE if ptr==entries-1. At most count transfers per route; the last fire is counted.
//  DONE: done=1 for one cycle; table cleared (entries=0, ptr=0) -> IDLE.
//  xbar_control holds the last issued word outside ISSUE. The crossbar keeps its last route after done.
//  path_en=0 in IDLE, ISSUE and DONE.
//  go and cfg_val are ignored while busy. Reset at any point aborts the run and clears the table.
//  Latency: go -> first xbar_control_val = 1 cycle. Last fire -> done = 1 cycle (2 cycles if DONE follows ISSUE skips).
// TESTING
//  1 Load {in1,out0,3},{in0,out1,2}; go -> control 42'h200_0000_0000 then 42'h100_0000_0000.
//    path_en high for exactly 3 then 2 fires; one done pulse; busy low after.
//  2 Hold xbar_control_rdy=0 for 4 cycles in ISSUE -> control_val and word stable; path_en=0; no counting.
//  3 Load {in0,out1,0},{in1,out1,1} -> first entry skipped (no control_val); single route issued; done after 1 fire.
//  4 Write 4 entries -> cfg_rdy=0; a 5th cfg_val is not stored. go with an empty table -> busy stays 0, no done.
//  5 In RUN, toggle mon_val/mon_rdy on the non-selected output -> counter unchanged; route is not advanced.
//  6 Assert reset mid-RUN -> next cycle all outputs at reset values, entries=0; new load+go runs normally.

Source files
------------

// File: rtl/xbar_route_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : xbar_route_scheduler_if
//  Purpose  : Bundles the route-table load port, run control, crossbar
//             control handshake and output monitor taps of the scheduler.
//  Revision : 1.0  initial release
// ============================================================================
interface xbar_route_scheduler_if #(
   parameter int N_INPUTS          = 2,
   parameter int N_OUTPUTS         = 2,
   parameter int CONTROL_BIT_WIDTH = 42,
   parameter int COUNT_WIDTH       = 8
);
   localparam int IW = $clog2(N_INPUTS);
   localparam int OW = $clog2(N_OUTPUTS);
   localparam int MW = IW + OW + COUNT_WIDTH;

   // route table load: {in_sel, out_sel, count}
   logic [MW-1:0]                cfg_msg;
   logic                         cfg_val;
   logic                         cfg_rdy;
   // run control and status
   logic                         go;
   logic                         busy;
   logic                         done;
   // crossbar control handshake and data-path gate
   logic [CONTROL_BIT_WIDTH-1:0] xbar_control;
   logic                         xbar_control_val;
   logic                         xbar_control_rdy;
   logic                         path_en;
   // per-output handshake taps from the crossbar
   logic [N_OUTPUTS-1:0]         mon_val;
   logic [N_OUTPUTS-1:0]         mon_rdy;

   // scheduler side
   modport slave (
      input  cfg_msg, cfg_val, go, xbar_control_rdy, mon_val, mon_rdy,
      output cfg_rdy, busy, done, xbar_control, xbar_control_val, path_en
   );

   // software / crossbar side
   modport master (
      output cfg_msg, cfg_val, go, xbar_control_rdy, mon_val, mon_rdy,
      input  cfg_rdy, busy, done, xbar_control, xbar_control_val, path_en
   );
endinterface
`default_nettype wire

// File: rtl/xbar_route_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : xbar_route_scheduler
//  Purpose  : Walks a programmed table of crossbar routes, issuing each
//             control word and counting completed transfers on the routed
//             output before moving on; pulses done after the last route.
//  Revision : 1.0  initial release
// ============================================================================
module xbar_route_scheduler #(
   parameter int N_INPUTS          = 2,
   parameter int N_OUTPUTS         = 2,
   parameter int CONTROL_BIT_WIDTH = 42,
   parameter int N_ENTRIES         = 4,
   parameter int COUNT_WIDTH       = 8
) (
   input  wire logic              clk,
   input  wire logic              reset,
   xbar_route_scheduler_if.slave  bus
);
   localparam int IW = $clog2(N_INPUTS);
   localparam int OW = $clog2(N_OUTPUTS);
   localparam int MW = IW + OW + COUNT_WIDTH;
   localparam int EW = $clog2(N_ENTRIES + 1);
   localparam int PW = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
   localparam int CW = CONTROL_BIT_WIDTH;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_RUN   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                 r_state;
   logic [MW-1:0]          r_table [N_ENTRIES];
   logic [EW-1:0]          r_entries;
   logic [PW-1:0]          r_ptr;
   logic [COUNT_WIDTH-1:0] r_count;
   logic [CW-1:0]          r_last_ctrl;
   logic                   r_busy;
   logic                   r_done;
   logic                   r_path_en;

   logic [MW-1:0]          w_entry;
   logic [COUNT_WIDTH-1:0] w_cnt;
   logic [OW-1:0]          w_osel;
   logic [CW-1:0]          w_word;
   logic                   w_last;
   logic                   w_cfg_rdy;
   logic                   w_cfg_wr;
   logic                   w_issue_val;
   logic                   w_mon_fire;

   // decode the current table entry into its fields and crossbar control word
   always_comb begin
      w_entry = r_table[r_ptr];
      w_cnt   = w_entry[COUNT_WIDTH-1:0];
      w_osel  = w_entry[COUNT_WIDTH +: OW];
      w_word  = '0;
      w_word[CW-1 -: IW+OW] = w_entry[MW-1:COUNT_WIDTH];
   end

   // the table only opens in IDLE, and stays closed while reset is held
   assign w_cfg_rdy   = !reset && (r_state == S_IDLE) && (r_entries < EW'(N_ENTRIES));
   assign w_cfg_wr    = bus.cfg_val && w_cfg_rdy;
   assign w_last      = ((EW'(r_ptr) + EW'(1)) == r_entries);
   // zero-count entries are skipped without ever raising control_val
   assign w_issue_val = (r_state == S_ISSUE) && (w_cnt != '0);
   assign w_mon_fire  = (r_state == S_RUN) && bus.mon_val[w_osel] && bus.mon_rdy[w_osel];

   assign bus.cfg_rdy          = w_cfg_rdy;
   assign bus.busy             = r_busy;
   assign bus.done             = r_done;
   assign bus.path_en          = r_path_en;
   assign bus.xbar_control_val = w_issue_val;
   assign bus.xbar_control     = w_issue_val ? w_word : r_last_ctrl;

   // route table writes plus the IDLE/ISSUE/RUN/DONE sequencer with its status flags
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_entries   <= '0;
         r_ptr       <= '0;
         r_count     <= '0;
         r_last_ctrl <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_path_en   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_cfg_wr) begin
            r_table[r_entries[PW-1:0]] <= bus.cfg_msg;
            r_entries                  <= r_entries + EW'(1);
         end
         case (r_state)
            S_IDLE: begin
               // an entry written alongside go counts toward a non-empty table
               if (bus.go && ((r_entries != '0) || w_cfg_wr)) begin
                  r_state <= S_ISSUE;
                  r_ptr   <= '0;
                  r_busy  <= 1'b1;
               end
            end
            S_ISSUE: begin
               if (w_cnt == '0) begin
                  if (w_last) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_ptr <= r_ptr + PW'(1);
                  end
               end else if (bus.xbar_control_rdy) begin
                  r_state     <= S_RUN;
                  r_count     <= '0;
                  r_path_en   <= 1'b1;
                  r_last_ctrl <= w_word;
               end
            end
            S_RUN: begin
               if (w_mon_fire) begin
                  r_count <= r_count + COUNT_WIDTH'(1);
                  // gate closes right after the final transfer so none crosses a route change
                  if (r_count == (w_cnt - COUNT_WIDTH'(1))) begin
                     r_path_en <= 1'b0;
                     if (w_last) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                     end else begin
                        r_state <= S_ISSUE;
                        r_ptr   <= r_ptr + PW'(1);
                     end
                  end
               end
            end
            S_DONE: begin
               r_state   <= S_IDLE;
               r_entries <= '0;
               r_ptr     <= '0;
               r_busy    <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_xbar_route_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_xbar_route_scheduler
//  Purpose  : Directed self-checking bench for xbar_route_scheduler.
//  Revision : 1.0  initial release
// ============================================================================
module tb_xbar_route_scheduler;
   localparam logic [41:0] C_I0O1 = 42'h100_0000_0000;
   localparam logic [41:0] C_I1O0 = 42'h200_0000_0000;
   localparam logic [41:0] C_I1O1 = 42'h300_0000_0000;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   xbar_route_scheduler_if #(
      .N_INPUTS(2), .N_OUTPUTS(2), .CONTROL_BIT_WIDTH(42), .COUNT_WIDTH(8)
   ) bus ();

   xbar_route_scheduler #(
      .N_INPUTS(2), .N_OUTPUTS(2), .CONTROL_BIT_WIDTH(42), .N_ENTRIES(4), .COUNT_WIDTH(8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic i, input logic o, input logic [7:0] n);
      bus.cfg_msg = {i, o, n};
      bus.cfg_val = 1'b1;
      tick();
      bus.cfg_val = 1'b0;
   endtask

   task automatic start();
      bus.go = 1'b1;
      tick();
      bus.go = 1'b0;
   endtask

   task automatic accept();
      bus.xbar_control_rdy = 1'b1;
      tick();
      bus.xbar_control_rdy = 1'b0;
   endtask

   // transfers offered on one output only while the route gate is open
   task automatic run_fires(input int o, input int n, output int fires, output int dones,
                            output int last_fire, output int done_at);
      fires = 0; dones = 0; last_fire = -1; done_at = -1;
      for (int c = 0; c < n; c++) begin
         if (bus.done) begin dones++; done_at = c; end
         bus.mon_val = '0;
         bus.mon_rdy = '0;
         if (bus.path_en) begin
            fires++;
            last_fire = c;
            bus.mon_val[o] = 1'b1;
            bus.mon_rdy[o] = 1'b1;
         end
         tick();
      end
      bus.mon_val = '0;
      bus.mon_rdy = '0;
   endtask

   // go, then crossbar always ready and every output transferring while gated open
   task automatic run_all(input int n, output int issues, output int fires, output int dones);
      issues = 0; fires = 0; dones = 0;
      start();
      bus.xbar_control_rdy = 1'b1;
      for (int c = 0; c < n; c++) begin
         if (bus.xbar_control_val) issues++;
         if (bus.done) dones++;
         if (bus.path_en) fires++;
         bus.mon_val = bus.path_en ? 2'b11 : 2'b00;
         bus.mon_rdy = bus.path_en ? 2'b11 : 2'b00;
         tick();
      end
      bus.xbar_control_rdy = 1'b0;
      bus.mon_val = '0;
      bus.mon_rdy = '0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.cfg_msg = '0; bus.cfg_val = 1'b0; bus.go = 1'b0; bus.xbar_control_rdy = 1'b0;
      bus.mon_val = '0; bus.mon_rdy = '0;
      tick(); tick(); tick();
      checks++; if (bus.cfg_rdy !== 1'b0) begin errors++; $display("FAIL rst_cfg_rdy: got %0b expected 0", bus.cfg_rdy); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b expected 0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_done: got %0b expected 0", bus.done); end
      checks++; if (bus.xbar_control !== 42'h0) begin errors++; $display("FAIL rst_ctrl: got %0h expected 0", bus.xbar_control); end
      checks++; if (bus.xbar_control_val !== 1'b0) begin errors++; $display("FAIL rst_ctrl_val: got %0b expected 0", bus.xbar_control_val); end
      checks++; if (bus.path_en !== 1'b0) begin errors++; $display("FAIL rst_path_en: got %0b expected 0", bus.path_en); end
      reset = 1'b0;
      tick();
      checks++; if (bus.cfg_rdy !== 1'b1) begin errors++; $display("FAIL rst_cfg_rdy_after: got %0b expected 1", bus.cfg_rdy); end
   endtask

   task automatic test_basic();
      int f, d, lf, da;
      load(1'b1, 1'b0, 8'd3);
      load(1'b0, 1'b1, 8'd2);
      start();
      checks++; if (bus.xbar_control_val !== 1'b1) begin errors++; $display("FAIL basic_val1: got %0b expected 1", bus.xbar_control_val); end
      checks++; if (bus.xbar_control !== C_I1O0) begin errors++; $display("FAIL basic_ctrl1: got %0h expected %0h", bus.xbar_control, C_I1O0); end
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %0b expected 1", bus.busy); end
      checks++; if (bus.path_en !== 1'b0) begin errors++; $display("FAIL basic_path_issue: got %0b expected 0", bus.path_en); end
      accept();
      checks++; if (bus.path_en !== 1'b1) begin errors++; $display("FAIL basic_path_run: got %0b expected 1", bus.path_en); end
      checks++; if (bus.xbar_control !== C_I1O0) begin errors++; $display("FAIL basic_ctrl_hold: got %0h expected %0h", bus.xbar_control, C_I1O0); end
      run_fires(0, 8, f, d, lf, da);
      checks++; if (f !== 3) begin errors++; $display("FAIL basic_fires1: got %0d expected 3", f); end
      checks++; if (d !== 0) begin errors++; $display("FAIL basic_done_early: got %0d expected 0", d); end
      checks++; if (bus.xbar_control_val !== 1'b1) begin errors++; $display("FAIL basic_val2: got %0b expected 1", bus.xbar_control_val); end
      checks++; if (bus.xbar_control !== C_I0O1) begin errors++; $display("FAIL basic_ctrl2: got %0h expected %0h", bus.xbar_control, C_I0O1); end
      accept();
      run_fires(1, 6, f, d, lf, da);
      checks++; if (f !== 2) begin errors++; $display("FAIL basic_fires2: got %0d expected 2", f); end
      checks++; if (d !== 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", d); end
      checks++; if (da !== lf + 1) begin errors++; $display("FAIL basic_done_latency: got %0d expected %0d", da, lf + 1); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %0b expected 0", bus.busy); end
      checks++; if (bus.xbar_control !== C_I0O1) begin errors++; $display("FAIL basic_ctrl_keep: got %0h expected %0h", bus.xbar_control, C_I0O1); end
   endtask

   task automatic test_skip();
      int f, d, lf, da;
      load(1'b0, 1'b1, 8'd0);
      load(1'b1, 1'b1, 8'd1);
      start();
      checks++; if (bus.xbar_control_val !== 1'b0) begin errors++; $display("FAIL skip_val: got %0b expected 0", bus.xbar_control_val); end
      checks++; if (bus.xbar_control !== C_I0O1) begin errors++; $display("FAIL skip_ctrl_hold: got %0h expected %0h", bus.xbar_control, C_I0O1); end
      tick();
      checks++; if (bus.xbar_control_val !== 1'b1) begin errors++; $display("FAIL skip_val2: got %0b expected 1", bus.xbar_control_val); end
      checks++; if (bus.xbar_control !== C_I1O1) begin errors++; $display("FAIL skip_ctrl2: got %0h expected %0h", bus.xbar_control, C_I1O1); end
      accept();
      run_fires(1, 5, f, d, lf, da);
      checks++; if (f !== 1) begin errors++; $display("FAIL skip_fires: got %0d expected 1", f); end
      checks++; if (d !== 1) begin errors++; $display("FAIL skip_done: got %0d expected 1", d); end
      // trailing zero-count entry: done arrives two cycles after the last transfer
      load(1'b1, 1'b0, 8'd2);
      load(1'b0, 1'b1, 8'd0);
      start();
      accept();
      run_fires(0, 8, f, d, lf, da);
      checks++; if (f !== 2) begin errors++; $display("FAIL skiptail_fires: got %0d expected 2", f); end
      checks++; if (d !== 1) begin errors++; $display("FAIL skiptail_done: got %0d expected 1", d); end
      checks++; if (da !== lf + 2) begin errors++; $display("FAIL skiptail_latency: got %0d expected %0d", da, lf + 2); end
   endtask

   task automatic test_stall();
      int f, d, lf, da;
      load(1'b1, 1'b1, 8'd2);
      start();
      for (int k = 0; k < 4; k++) begin
         bus.mon_val = 2'b11;
         bus.mon_rdy = 2'b11;
         checks++; if (bus.xbar_control_val !== 1'b1) begin errors++; $display("FAIL stall_val[%0d]: got %0b expected 1", k, bus.xbar_control_val); end
         checks++; if (bus.xbar_control !== C_I1O1) begin errors++; $display("FAIL stall_ctrl[%0d]: got %0h expected %0h", k, bus.xbar_control, C_I1O1); end
         checks++; if (bus.path_en !== 1'b0) begin errors++; $display("FAIL stall_path[%0d]: got %0b expected 0", k, bus.path_en); end
         tick();
      end
      bus.mon_val = '0;
      bus.mon_rdy = '0;
      accept();
      run_fires(1, 6, f, d, lf, da);
      checks++; if (f !== 2) begin errors++; $display("FAIL stall_fires: got %0d expected 2", f); end
      checks++; if (d !== 1) begin errors++; $display("FAIL stall_done: got %0d expected 1", d); end
   endtask

   task automatic test_full();
      int iss, f, d;
      for (int k = 0; k < 4; k++) begin
         checks++; if (bus.cfg_rdy !== 1'b1) begin errors++; $display("FAIL full_rdy[%0d]: got %0b expected 1", k, bus.cfg_rdy); end
         load((k % 2) == 1, 1'b0, 8'd1);
      end
      checks++; if (bus.cfg_rdy !== 1'b0) begin errors++; $display("FAIL full_rdy_full: got %0b expected 0", bus.cfg_rdy); end
      load(1'b1, 1'b1, 8'd5);
      run_all(40, iss, f, d);
      checks++; if (iss !== 4) begin errors++; $display("FAIL full_issues: got %0d expected 4", iss); end
      checks++; if (f !== 4) begin errors++; $display("FAIL full_fires: got %0d expected 4", f); end
      checks++; if (d !== 1) begin errors++; $display("FAIL full_done: got %0d expected 1", d); end
      start();
      for (int k = 0; k < 3; k++) begin
         checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL empty_busy[%0d]: got %0b expected 0", k, bus.busy); end
         checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL empty_done[%0d]: got %0b expected 0", k, bus.done); end
         tick();
      end
   endtask

   task automatic test_other_output();
      int f, d, lf, da;
      load(1'b0, 1'b1, 8'd2);
      start();
      accept();
      for (int k = 0; k < 6; k++) begin
         checks++; if (bus.path_en !== 1'b1) begin errors++; $display("FAIL other_path[%0d]: got %0b expected 1", k, bus.path_en); end
         bus.mon_val = {k == 3, (k % 2) == 0};
         bus.mon_rdy = 2'b01;
         tick();
      end
      bus.mon_val = '0;
      bus.mon_rdy = '0;
      run_fires(1, 6, f, d, lf, da);
      checks++; if (f !== 2) begin errors++; $display("FAIL other_fires: got %0d expected 2", f); end
      checks++; if (d !== 1) begin errors++; $display("FAIL other_done: got %0d expected 1", d); end
   endtask

   task automatic test_reset_mid_run();
      int iss, f, d, lf, da;
      load(1'b1, 1'b0, 8'd5);
      load(1'b0, 1'b1, 8'd1);
      start();
      accept();
      run_fires(0, 2, f, d, lf, da);
      reset = 1'b1;
      tick();
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %0b expected 0", bus.busy); end
      checks++; if (bus.path_en !== 1'b0) begin errors++; $display("FAIL mid_path: got %0b expected 0", bus.path_en); end
      checks++; if (bus.xbar_control !== 42'h0) begin errors++; $display("FAIL mid_ctrl: got %0h expected 0", bus.xbar_control); end
      checks++; if (bus.xbar_control_val !== 1'b0) begin errors++; $display("FAIL mid_val: got %0b expected 0", bus.xbar_control_val); end
      checks++; if (bus.cfg_rdy !== 1'b0) begin errors++; $display("FAIL mid_cfg_rdy: got %0b expected 0", bus.cfg_rdy); end
      reset = 1'b0;
      tick();
      start();
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_table_cleared: got %0b expected 0", bus.busy); end
      load(1'b1, 1'b1, 8'd1);
      run_all(20, iss, f, d);
      checks++; if (iss !== 1) begin errors++; $display("FAIL mid_issues: got %0d expected 1", iss); end
      checks++; if (f !== 1) begin errors++; $display("FAIL mid_fires: got %0d expected 1", f); end
      checks++; if (d !== 1) begin errors++; $display("FAIL mid_done: got %0d expected 1", d); end
      checks++; if (bus.xbar_control !== C_I1O1) begin errors++; $display("FAIL mid_ctrl_final: got %0h expected %0h", bus.xbar_control, C_I1O1); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_skip();
      test_stall();
      test_full();
      test_other_output();
      test_reset_mid_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
